generador_tono: RTL
===================

GENERADOR_TONO -- requirements
Module: generador_tono

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter TICK_CYCLES, default 5_000_000, meaning clk cycles per duration tick (0.1 s); benches override it.
REQ-003 The block SHALL have port clk  input  1  system clock, sole clock domain.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port nota  input  3  note code from the free-mode FSM: 0 = silence, 1 = C4, 2 = D4, 3 = E4, 4 = F4, 5-7 = invalid.
REQ-006 The block SHALL have port contar  input  1  high while a key is held (from the free-mode FSM).
REQ-007 The block SHALL have port audio  output  1  square-wave speaker drive.
REQ-008 The block SHALL have port sonando  output  1  high while a valid note is sounding.
REQ-009 The block SHALL have port duracion  output  7  held time of the last completed note, in ticks.
REQ-010 The block SHALL have port fin_nota  output  1  one-cycle pulse when duracion updates.

Function
REQ-011 The block SHALL register nota and contar once (nota_r, contar_r) and make all decisions from the registered copies.
REQ-012 The FSM SHALL have two states: SILENCIO and SONANDO.
REQ-013 SILENCIO -> SONANDO SHALL occur when contar_r=1 and nota_r is in 1..4; otherwise the FSM stays in SILENCIO.
REQ-014 SONANDO -> SILENCIO SHALL occur when contar_r=0 or nota_r is not in 1..4.
REQ-015 The half-period for each note SHALL be the rounded value of CLK_HZ/(2*f): C4 95556, D4 85131, E4 75843, F4 71586 at the default clock.
REQ-016 The divider counter SHALL be 17 bits wide, count 0..HALF-1 while in SONANDO, toggle audio when it reaches HALF-1, and then wrap to 0.
REQ-017 On entry to SONANDO, the divider and audio SHALL start from 0, so the first audio rise occurs HALF cycles after the entry edge.
REQ-018 If nota_r changes between two valid codes while in SONANDO, the divider and audio SHALL restart from 0 on the next edge, and the duration count SHALL continue without interruption.
REQ-019 In SILENCIO, audio and the divider SHALL be held at 0.
REQ-020 sonando SHALL be 1 exactly when the state is SONANDO.
REQ-021 The tick prescaler SHALL count 0..TICK_CYCLES-1 only in SONANDO, and each wrap SHALL increment the hold counter.
REQ-022 The hold counter SHALL saturate at 99.
REQ-023 The prescaler and hold counter SHALL both clear on entry to SONANDO.
REQ-024 On the SONANDO -> SILENCIO edge, duracion SHALL load the hold counter value (a final partial tick is discarded), and fin_nota SHALL be 1 for exactly that one cycle.
REQ-025 duracion SHALL hold its value until the next note ends.
REQ-026 A tick wrap coinciding with the exit edge SHALL be counted, subject to the saturation limit.
REQ-027 contar=1 with nota=0 or an invalid code SHALL produce no sound and no fin_nota.

Reset
REQ-028 While reset=1 at a clk edge, the state SHALL go to SILENCIO and nota_r, contar_r, the divider, the prescaler, the hold counter, audio, sonando, duracion and fin_nota SHALL all clear to 0.
REQ-029 A reset asserted during SONANDO SHALL produce no fin_nota pulse and SHALL leave duracion at 0.
REQ-030 After reset deasserts, the first transition SHALL occur no earlier than the edge after contar is sampled.

Structure
REQ-031 The note codes (NOTA_SIL, NOTA_C..NOTA_F), the note frequencies and the half-period derivation function SHALL live in the shared package notas_pkg, which the free-mode FSM also uses.
REQ-032 The programmable divider (restart input, half-period input, audio output) SHALL be a separate sub-module named divisor_tono.
REQ-033 The FSM, the tick prescaler and the duration latch SHALL live in the generador_tono top level.

Verification
REQ-034 The bench SHALL cover: reset, then contar=1 with nota=1 held for 200000 cycles -> audio first rises 95556 cycles after the SONANDO entry edge, and its period is 191112 cycles.
REQ-035 The bench SHALL cover: TICK_CYCLES=100, nota=2 held for 750 cycles, then contar=0 -> fin_nota is a single one-cycle pulse and duracion=7.
REQ-036 The bench SHALL cover: TICK_CYCLES=10, nota=3 held for 2000 cycles -> duracion=99 (saturated) at release.
REQ-037 The bench SHALL cover: nota switching from 1 to 4 mid-note -> audio drops to 0 on the following edge, the next rise comes 71586 cycles later, and sonando stays 1 throughout.
REQ-038 The bench SHALL cover: contar=1 with nota=6 -> audio=0, sonando=0, fin_nota never asserts.
REQ-039 The bench SHALL cover: reset pulsed during SONANDO -> all outputs are 0 on the next edge and no fin_nota occurs.

Source files
------------

// File: rtl/notas_pkg.sv
// Shared note codes, note frequencies and half-period derivation for the tone
// generator and the free-mode FSM.
package notas_pkg;

    localparam int unsigned NOTA_W = 3;
    localparam int unsigned HALF_W = 17;

    localparam logic [NOTA_W-1:0] NOTA_SIL = 3'd0;
    localparam logic [NOTA_W-1:0] NOTA_C   = 3'd1;
    localparam logic [NOTA_W-1:0] NOTA_D   = 3'd2;
    localparam logic [NOTA_W-1:0] NOTA_E   = 3'd3;
    localparam logic [NOTA_W-1:0] NOTA_F   = 3'd4;

    // Equal-temperament fourth octave, in millihertz
    localparam longint unsigned FREQ_C_MHZ = 64'd261626;
    localparam longint unsigned FREQ_D_MHZ = 64'd293665;
    localparam longint unsigned FREQ_E_MHZ = 64'd329628;
    localparam longint unsigned FREQ_F_MHZ = 64'd349228;

    function automatic logic nota_valida(input logic [NOTA_W-1:0] nota);
        return (nota >= NOTA_C) && (nota <= NOTA_F);
    endfunction

    // Rounded clk_hz / (2 * f); meant for elaboration-time constants only
    function automatic logic [HALF_W-1:0] half_period(input longint unsigned clk_hz,
                                                      input longint unsigned f_mhz);
        longint unsigned half;
        if (f_mhz == 64'd0) begin
            half = 64'd0;
        end else begin
            half = (clk_hz * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
        end
        return HALF_W'(half);
    endfunction

endpackage

// File: rtl/divisor_tono.sv
// Programmable square-wave divider: toggles audio every 'half' cycles and
// restarts from a low output whenever restart is asserted.
module divisor_tono
    import notas_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [HALF_W-1:0] half,
    output logic              audio
);

    logic [HALF_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt   <= '0;
            audio <= 1'b0;
        end else if (cnt == half - HALF_W'(1)) begin
            cnt   <= '0;
            audio <= ~audio;
        end else begin
            cnt   <= cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/generador_tono.sv
// Tone generator: plays the selected note while a key is held and reports how
// long the last note was held, in 0.1 s ticks saturating at 99.
module generador_tono
    import notas_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TICK_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTA_W-1:0] nota,
    input  logic              contar,
    output logic              audio,
    output logic              sonando,
    output logic [6:0]        duracion,
    output logic              fin_nota
);

    localparam int unsigned DUR_W   = 7;
    localparam int unsigned DUR_MAX = 99;
    localparam int unsigned PRE_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [0:0] SILENCIO = 1'b0;
    localparam logic [0:0] SONANDO  = 1'b1;

    localparam logic [HALF_W-1:0] HALF_C = half_period(64'(CLK_HZ), FREQ_C_MHZ);
    localparam logic [HALF_W-1:0] HALF_D = half_period(64'(CLK_HZ), FREQ_D_MHZ);
    localparam logic [HALF_W-1:0] HALF_E = half_period(64'(CLK_HZ), FREQ_E_MHZ);
    localparam logic [HALF_W-1:0] HALF_F = half_period(64'(CLK_HZ), FREQ_F_MHZ);

    logic [0:0]        state, state_next;
    logic [NOTA_W-1:0] nota_r, nota_act;
    logic              contar_r;
    logic [PRE_W-1:0]  pre, pre_next;
    logic [DUR_W-1:0]  hold, hold_next, dur_next;
    logic              fin_next;
    logic              valida_c, tick_c, restart_c;
    logic [HALF_W-1:0] half_c;

    // Input capture; nota_act remembers the previously sampled note to spot changes
    always_ff @(posedge clk) begin
        if (reset) begin
            nota_r   <= '0;
            contar_r <= 1'b0;
            nota_act <= '0;
        end else begin
            nota_r   <= nota;
            contar_r <= contar;
            nota_act <= nota_r;
        end
    end

    assign valida_c = contar_r && nota_valida(nota_r);

    always_comb begin
        state_next = state;
        pre_next   = '0;
        hold_next  = '0;
        dur_next   = duracion;
        fin_next   = 1'b0;
        tick_c     = (pre == PRE_W'(TICK_CYCLES - 1));
        case (state)
            SILENCIO: begin
                if (valida_c) state_next = SONANDO;
            end
            SONANDO: begin
                pre_next  = tick_c ? '0 : pre + PRE_W'(1);
                hold_next = (tick_c && hold != DUR_W'(DUR_MAX)) ? hold + DUR_W'(1) : hold;
                if (!valida_c) begin
                    state_next = SILENCIO;
                    dur_next   = hold_next;
                    fin_next   = 1'b1;
                end
            end
            default: state_next = SILENCIO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SILENCIO;
            pre      <= '0;
            hold     <= '0;
            sonando  <= 1'b0;
            duracion <= '0;
            fin_nota <= 1'b0;
        end else begin
            state    <= state_next;
            pre      <= pre_next;
            hold     <= hold_next;
            sonando  <= (state_next == SONANDO);
            duracion <= dur_next;
            fin_nota <= fin_next;
        end
    end

    always_comb begin
        case (nota_r)
            NOTA_C:   half_c = HALF_C;
            NOTA_D:   half_c = HALF_D;
            NOTA_E:   half_c = HALF_E;
            NOTA_F:   half_c = HALF_F;
            NOTA_SIL: half_c = '0;
            default:  half_c = '0;
        endcase
    end

    // Divider runs only while a note keeps sounding with an unchanged code
    assign restart_c = (state != SONANDO) || (state_next != SONANDO) || (nota_r != nota_act);

    divisor_tono u_div (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_c),
        .half    (half_c),
        .audio   (audio)
    );

endmodule
